// File: rtl/tlb_if.sv
`default_nettype none
// ============================================================================
// Module   : tlb_if
// Brief    : Lookup, write and read bundle shared by the TLB and its callers.
// Revision : 1.0 - initial release
// ============================================================================
interface tlb_if #(
    parameter int IDX_W = 4
);
    // lookup port 0 (fetch side)
    logic [18:0]      s0_vpn2;
    logic             s0_odd_page;
    logic [7:0]       s0_asid;
    logic             s0_found;
    logic [IDX_W-1:0] s0_index;
    logic [19:0]      s0_pfn;
    logic [2:0]       s0_c;
    logic             s0_d;
    logic             s0_v;

    // lookup port 1 (data side)
    logic [18:0]      s1_vpn2;
    logic             s1_odd_page;
    logic [7:0]       s1_asid;
    logic             s1_found;
    logic [IDX_W-1:0] s1_index;
    logic [19:0]      s1_pfn;
    logic [2:0]       s1_c;
    logic             s1_d;
    logic             s1_v;

    // entry write (TLBWI/TLBWR)
    logic             we;
    logic [IDX_W-1:0] w_index;
    logic [18:0]      w_vpn2;
    logic [7:0]       w_asid;
    logic             w_g;
    logic [19:0]      w_pfn0;
    logic [2:0]       w_c0;
    logic             w_d0;
    logic             w_v0;
    logic [19:0]      w_pfn1;
    logic [2:0]       w_c1;
    logic             w_d1;
    logic             w_v1;

    // entry read (TLBR)
    logic [IDX_W-1:0] r_index;
    logic [18:0]      r_vpn2;
    logic [7:0]       r_asid;
    logic             r_g;
    logic [19:0]      r_pfn0;
    logic [2:0]       r_c0;
    logic             r_d0;
    logic             r_v0;
    logic [19:0]      r_pfn1;
    logic [2:0]       r_c1;
    logic             r_d1;
    logic             r_v1;

    modport master (
        output s0_vpn2, s0_odd_page, s0_asid,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_vpn2, s1_odd_page, s1_asid,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output we, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        input  r_pfn1, r_c1, r_d1, r_v1
    );

    modport slave (
        input  s0_vpn2, s0_odd_page, s0_asid,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_vpn2, s1_odd_page, s1_asid,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  we, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        output r_pfn1, r_c1, r_d1, r_v1
    );
endinterface
`default_nettype wire

// File: rtl/tlb_core.sv
`default_nettype none
// ============================================================================
// Module   : tlb_core
// Brief    : Register-based fully associative TLB, two combinational lookup
//            ports, one write port and one combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_core #(
    parameter int TLBNUM = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    tlb_if.slave      bus
);
    localparam int IDX_W = $clog2(TLBNUM);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
        logic [19:0]      pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } result_t;

    entry_t  r_tlb [TLBNUM];
    result_t w_s0;
    result_t w_s1;
    entry_t  w_rd;

    // Priority runs high-to-low so the lowest matching index is the one kept.
    function automatic result_t lookup(input logic [18:0] vpn2,
                                       input logic        odd,
                                       input logic [7:0]  asid);
        result_t           res;
        entry_t            sel;
        logic [TLBNUM-1:0] hit;
        res = '0;
        sel = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            hit[i] = (r_tlb[i].vpn2 == vpn2) &&
                     (r_tlb[i].g || (r_tlb[i].asid == asid));
        end
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                res.index = IDX_W'(i);
                sel       = r_tlb[i];
            end
        end
        res.found = |hit;
        if (res.found) begin
            if (odd) begin
                res.pfn = sel.pfn1;
                res.c   = sel.c1;
                res.d   = sel.d1;
                res.v   = sel.v1;
            end else begin
                res.pfn = sel.pfn0;
                res.c   = sel.c0;
                res.d   = sel.d0;
                res.v   = sel.v0;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_s0 = lookup(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid);
        w_s1 = lookup(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid);
        w_rd = r_tlb[bus.r_index];
    end

    assign bus.s0_found = w_s0.found;
    assign bus.s0_index = w_s0.index;
    assign bus.s0_pfn   = w_s0.pfn;
    assign bus.s0_c     = w_s0.c;
    assign bus.s0_d     = w_s0.d;
    assign bus.s0_v     = w_s0.v;

    assign bus.s1_found = w_s1.found;
    assign bus.s1_index = w_s1.index;
    assign bus.s1_pfn   = w_s1.pfn;
    assign bus.s1_c     = w_s1.c;
    assign bus.s1_d     = w_s1.d;
    assign bus.s1_v     = w_s1.v;

    assign bus.r_vpn2 = w_rd.vpn2;
    assign bus.r_asid = w_rd.asid;
    assign bus.r_g    = w_rd.g;
    assign bus.r_pfn0 = w_rd.pfn0;
    assign bus.r_c0   = w_rd.c0;
    assign bus.r_d0   = w_rd.d0;
    assign bus.r_v0   = w_rd.v0;
    assign bus.r_pfn1 = w_rd.pfn1;
    assign bus.r_c1   = w_rd.c1;
    assign bus.r_d1   = w_rd.d1;
    assign bus.r_v1   = w_rd.v1;

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_tlb[i] <= '0;
            end
        end else if (bus.we) begin
            r_tlb[bus.w_index] <= {bus.w_vpn2, bus.w_asid, bus.w_g,
                                   bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                                   bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1};
        end
    end
endmodule
`default_nettype wire

// File: doc/tlb_core.md
TLB_CORE -- requirements
Module: tlb_core

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning the entry count; the index width is log2(TLBNUM), 4 at the default.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have lookup port 0 inputs s0_vpn2 (19), s0_odd_page (1) and s0_asid (8): the fetch-side request.
REQ-005 SHALL have lookup port 0 outputs s0_found (1), s0_index (4), s0_pfn (20), s0_c (3), s0_d (1) and s0_v (1).
REQ-006 SHALL have lookup port 1 inputs s1_vpn2 (19), s1_odd_page (1) and s1_asid (8): the data-side request driven by the MEM0 translation bridge.
REQ-007 SHALL have lookup port 1 outputs s1_found (1), s1_index (4), s1_pfn (20), s1_c (3), s1_d (1) and s1_v (1).
REQ-008 SHALL have write port inputs we (1), w_index (4), w_vpn2 (19), w_asid (8) and w_g (1): TLBWI/TLBWR entry write.
REQ-009 SHALL have write page inputs w_pfn0/w_pfn1 (20 each), w_c0/w_c1 (3 each), w_d0/w_d1 (1 each) and w_v0/w_v1 (1 each).
REQ-010 SHALL have read port input r_index (4) and outputs r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1 and r_v0/1, with widths as on the write port: TLBR.

Function
REQ-011 SHALL store TLBNUM entries as registers, each holding {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}.
REQ-012 SHALL flag entry i as a match on port k when entry.vpn2 == sk_vpn2 and (entry.g == 1 or entry.asid == sk_asid).
REQ-013 SHALL compute lookups combinationally, with zero cycles of latency, because the bridge consumes s1_* in the same cycle.
REQ-014 SHALL drive sk_found = OR of all match flags.
REQ-015 SHALL drive sk_index as the lowest matching index, and 0 when no entry matches.
REQ-016 SHALL select the odd page (pfn1, c1, d1, v1) of the chosen entry when sk_odd_page = 1, and the even page (pfn0, c0, d0, v0) otherwise.
REQ-017 SHALL drive sk_pfn/c/d/v all-zero when sk_found = 0.
REQ-018 SHALL NOT suppress a match when the selected v = 0; the bridge raises the invalid exception, not refill.
REQ-019 SHALL, when we = 1, write all w_* fields into entry w_index at the clock edge.
REQ-020 SHALL make the written entry visible to lookup and read from the next cycle onward.
REQ-021 SHALL make lookups and reads in the write cycle return the pre-write contents, including on same-index collisions.
REQ-022 SHALL make the read port a combinational view of entry r_index.
REQ-023 SHALL drive s0 and s1 independently and allow both to hit the same entry in the same cycle.
REQ-024 SHALL have no handshake: requests are valid every cycle, and the caller qualifies results with its own mapped/load/store terms.

Reset
REQ-025 SHALL, on reset = 1 at a clock edge, clear every field of every entry to 0, including g = 0.
REQ-026 SHALL give reset priority over we in the same cycle; the write is discarded.
REQ-027 SHALL, after reset, make a lookup of vpn2 = 0 with asid = 0 return found = 1, index = 0, pfn = 0, v = 0, d = 0; software initialises the TLB before enabling mapped access.
REQ-028 SHALL, after reset, make a lookup of any nonzero vpn2 return found = 0.

Verification
REQ-029 SHALL cover write-then-hit: write idx 3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0x00ABC, v0=1, d0=1}; the next cycle s1 {0x12345, odd=0, asid=0x05} gives found=1, index=3, pfn=0x00ABC, v=1, d=1.
REQ-030 SHALL cover ASID miss versus global: the same lookup with asid=0x06 gives found=0; rewriting idx 3 with g=1 then gives found=1 for asid=0x06.
REQ-031 SHALL cover odd page: idx 3 with pfn1=0x00DEF, v1=0, d1=0 and s1_odd_page=1 gives found=1, pfn=0x00DEF, v=0, d=0.
REQ-032 SHALL cover duplicate entries: idx 2 and idx 7 with equal vpn2/asid give index=2; the same-cycle write of idx 2 plus lookup shows the old idx-2 data, and the new data appears the next cycle.
REQ-033 SHALL cover dual port: s0 hits idx 3 while s1 misses, in the same cycle, with independent correct outputs.
REQ-034 SHALL cover reset with we=1 in the same cycle: all r_* for every index read 0, and s1 with vpn2=0x12345 gives found=0.
